// File: rtl/mul16_seq.sv
// ---------------------------------------------------------------------------
// mul16_seq - sequential 16x16 unsigned shift-and-add multiplier.
//
// Each RUN cycle ANDs the captured multiplicand with one replicated multiplier
// bit (the and16 gate) and adds the shifted partial product into a 32-bit
// accumulator. Iteration count is fixed at 16, so latency is always 17 cycles
// from the accepted start edge to the done pulse.
//
// Ports:
//   clock    in   1   single clock, rising-edge
//   reset    in   1   synchronous, active-high
//   start    in   1   request, sampled only in IDLE
//   a        in  16   multiplicand, captured on accepted start
//   b        in  16   multiplier, captured on accepted start
//   busy     out  1   high in RUN and DONE
//   done     out  1   one-cycle pulse, product valid
//   product  out 32   a*b, held until next accepted start
// ---------------------------------------------------------------------------

// Hack-style 16-bit bitwise AND gate.
module and16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] out
);
   assign out = a & b;
endmodule

module mul16_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [31:0] product_q, product_d;
   logic [3:0]  count_q, count_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [15:0] partial;

   // Partial product for the current iteration: multiplicand gated by one
   // multiplier bit replicated across all 16 lanes.
   and16 u_and16 (
      .a   (a_q),
      .b   ({16{b_q[count_q]}}),
      .out (partial)
   );

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case leaves it unassigned, which would infer a latch.
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      product_d = product_q;
      count_d   = count_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d       = a;
               b_d       = b;
               product_d = 32'd0;
               count_d   = 4'd0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            // 32-bit accumulation: 0xFFFF*0xFFFF fits, so no carry-out exists.
            product_d = product_q + ({16'd0, partial} << count_q);
            count_d   = count_q + 4'd1;
            if (count_q == 4'd15) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // with the state they describe without a combinational decode.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      // NOTE: state updates use non-blocking assignments so all registers
      // sample their _d values from the same edge regardless of order.
      if (reset) begin
         // NOTE: operand registers are reset too; they are few and it keeps
         // the datapath free of X after reset.
         state_q   <= ST_IDLE;
         a_q       <= 16'd0;
         b_q       <= 16'd0;
         product_q <= 32'd0;
         count_q   <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         product_q <= product_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_mul16_seq.sv
// ---------------------------------------------------------------------------
// tb_mul16_seq - directed self-checking bench for mul16_seq.
// Inputs are driven and outputs sampled on the falling edge of clock, away
// from the rising edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_mul16_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a     = 16'd0;
   logic [15:0] b     = 16'd0;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int checks = 0;
   int fails  = 0;

   mul16_seq dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   // Present operands and raise start on a falling edge; the next rising
   // edge is the accepting edge.
   task automatic launch(input logic [15:0] av, input logic [15:0] bv);
      @(negedge clock);
      a     = av;
      b     = bv;
      start = 1'b1;
   endtask

   // Drop start after the accepting edge and wait (bounded) for done.
   // lat = falling edges after the accepting edge until done, 0 on timeout.
   task automatic wait_done(output int lat, output int busy_low);
      lat      = 0;
      busy_low = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (n == 1) start = 1'b0;
         if (!busy) busy_low++;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b1;
      a     = 16'h0003;
      b     = 16'h0005;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checks++;
         if ({busy, done, product} !== 34'd0) begin
            fails++;
            $display("FAIL reset_hold[%0d]: busy=%b done=%b product=%h expected 0 0 00000000",
                     i, busy, done, product);
         end
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      checks++;
      if ({busy, done, product} !== 34'd0) begin
         fails++;
         $display("FAIL reset_idle: busy=%b done=%b product=%h expected 0 0 00000000",
                  busy, done, product);
      end
   endtask

   task automatic test_basic;
      int lat, busy_low;
      launch(16'h0003, 16'h0005);
      wait_done(lat, busy_low);
      checks++;
      if (lat !== 17) begin
         fails++;
         $display("FAIL basic_latency: got %0d expected 17", lat);
      end
      checks++;
      if (busy_low !== 0) begin
         fails++;
         $display("FAIL basic_busy: busy low in %0d cycles expected 0", busy_low);
      end
      checks++;
      if (product !== 32'h0000000F) begin
         fails++;
         $display("FAIL basic_product: got %h expected 0000000f", product);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || product !== 32'h0000000F) begin
            fails++;
            $display("FAIL basic_hold[%0d]: done=%b busy=%b product=%h expected 0 0 0000000f",
                     i, done, busy, product);
         end
      end
   endtask

   task automatic test_vectors;
      vec_t vecs[6];
      int   lat, busy_low;
      vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      vecs[1] = '{16'h0000, 16'hFFFF, 32'h00000000};
      vecs[2] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
      vecs[3] = '{16'hAAAA, 16'h5555, 32'h38E31C72};
      vecs[4] = '{16'h1234, 16'h9876, 32'h0AD743F8};
      vecs[5] = '{16'h3CC3, 16'h0FF0, 32'h0};
      vecs[5].p = {16'd0, vecs[5].a} * {16'd0, vecs[5].b};
      foreach (vecs[i]) begin
         launch(vecs[i].a, vecs[i].b);
         wait_done(lat, busy_low);
         checks++;
         if (lat !== 17 || product !== vecs[i].p) begin
            fails++;
            $display("FAIL vector %h*%h: product=%h latency=%0d expected %h latency 17",
                     vecs[i].a, vecs[i].b, product, lat, vecs[i].p);
         end
      end
   endtask

   task automatic test_abuse;
      int          first_done = 0;
      int          pulses     = 0;
      int          idle_busy  = 0;
      logic [31:0] p_done     = 32'hX;
      launch(16'h0002, 16'h0003);
      for (int n = 1; n <= 22; n++) begin
         @(negedge clock);
         case (n)
            1:  start = 1'b0;
            3:  begin a = 16'hFFFF; b = 16'hFFFF; start = 1'b1; end
            4:  start = 1'b0;
            8:  begin a = 16'h1234; b = 16'h5678; end
            16: begin a = 16'hFFFF; b = 16'hFFFF; start = 1'b1; end
            18: start = 1'b0;
            default: ;
         endcase
         if (done) begin
            pulses++;
            if (first_done == 0) begin
               first_done = n;
               p_done     = product;
            end
         end
         if (n >= 19 && busy) idle_busy++;
      end
      checks++;
      if (first_done !== 17 || p_done !== 32'h00000006) begin
         fails++;
         $display("FAIL abuse_result: done at %0d product=%h expected 17 00000006",
                  first_done, p_done);
      end
      checks++;
      if (pulses !== 1) begin
         fails++;
         $display("FAIL abuse_pulses: got %0d expected 1", pulses);
      end
      checks++;
      if (idle_busy !== 0 || product !== 32'h00000006) begin
         fails++;
         $display("FAIL abuse_no_queue: busy cycles=%0d product=%h expected 0 00000006",
                  idle_busy, product);
      end
   endtask

   task automatic test_back_to_back;
      int          first  = 0;
      int          second = 0;
      logic [31:0] p1 = 32'hX, p2 = 32'hX, p19 = 32'hX;
      logic        busy18 = 1'bX, busy19 = 1'bX;
      launch(16'h0004, 16'h0005);
      for (int n = 1; n <= 45; n++) begin
         @(negedge clock);
         if (n == 17) begin a = 16'h0006; b = 16'h0007; end
         if (n == 19) start = 1'b0;
         if (n == 18) busy18 = busy;
         if (n == 19) begin busy19 = busy; p19 = product; end
         if (done) begin
            if (first == 0) begin first = n; p1 = product; end
            else if (second == 0) begin second = n; p2 = product; end
         end
      end
      checks++;
      if (first !== 17 || p1 !== 32'h00000014) begin
         fails++;
         $display("FAIL b2b_first: done at %0d product=%h expected 17 00000014", first, p1);
      end
      checks++;
      if (busy18 !== 1'b0 || busy19 !== 1'b1 || p19 !== 32'h0) begin
         fails++;
         $display("FAIL b2b_gap: busy18=%b busy19=%b product19=%h expected 0 1 00000000",
                  busy18, busy19, p19);
      end
      checks++;
      if (second !== 35 || p2 !== 32'h0000002A) begin
         fails++;
         $display("FAIL b2b_second: done at %0d product=%h expected 35 0000002a", second, p2);
      end
   endtask

   task automatic test_reset_mid;
      int pulses = 0;
      int lat, busy_low;
      launch(16'hFFFF, 16'hFFFF);
      for (int n = 1; n <= 25; n++) begin
         @(negedge clock);
         if (n == 1) start = 1'b0;
         if (n == 8) begin
            reset = 1'b1;
            start = 1'b1;
         end
         if (n == 9) begin
            reset = 1'b0;
            start = 1'b0;
            checks++;
            if ({busy, done, product} !== 34'd0) begin
               fails++;
               $display("FAIL reset_mid: busy=%b done=%b product=%h expected 0 0 00000000",
                        busy, done, product);
            end
         end
         if (done) pulses++;
      end
      checks++;
      if (pulses !== 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_no_done: pulses=%0d busy=%b expected 0 0", pulses, busy);
      end
      launch(16'h0007, 16'h0009);
      wait_done(lat, busy_low);
      checks++;
      if (lat !== 17 || product !== 32'h0000003F) begin
         fails++;
         $display("FAIL reset_mid_after: product=%h latency=%0d expected 0000003f latency 17",
                  product, lat);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_abuse();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
